tank_sprite_loader: RTL and testbench

//  Sprite-memory responder for the tank draw stage. Serves pixel_addr reads with rgb_pixel
//  one clk later; drawing samples rgb_pixel two stages after hcount/vcount.

---
 rtl/tank_sprite_loader.sv | 181 ++++++++++++++++++
 tb/tb_tank_sprite_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_sprite_loader.sv
// Tank sprite responder: registered pixel read port plus a rotating rebuild copy from the sprite ROM.
// Optional double buffering with vblank-synchronised swap is enabled by defining TANK_SPRITE_DBUF_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for load_req; busy low
// WAIT_VBL | request accepted and heading latched; waiting for vblnk_in
// COPY     | one ROM address issued per clk, d = 0..4095
// FLUSH    | last ROM word in flight to the image RAM
// SWAP     | (double buffer only) waiting for vblnk_in to flip the active buffer
// DONE     | done pulse cycle; busy already low
module tank_sprite_loader #(
  parameter int AW   = 12,
  parameter int DW   = 12,
  parameter int NPIX = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pixel_addr,
  output logic [DW-1:0] rgb_pixel,
  input  logic          vblnk_in,
  input  logic [1:0]    dir,
  input  logic          load_req,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam int HW = AW / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

`ifdef TANK_SPRITE_DBUF_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VBL,
    S_COPY,
    S_FLUSH,
    S_SWAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    dir_q;
  logic [AW-1:0] d;
  logic [AW-1:0] src_addr;
  logic          iss_vld;
  logic [AW-1:0] iss_idx;
  logic          wr_vld;
  logic [AW-1:0] wr_idx;

  logic [DW-1:0] mem [NBUF*NPIX];

`ifdef TANK_SPRITE_DBUF_EN
  logic active;
`endif

  // Destination-to-source rotation; 63-v is just the bitwise complement of a 6-bit field.
  logic [HW-1:0] dy, dx;
  assign dy = d[AW-1:HW];
  assign dx = d[HW-1:0];

  always_comb begin
    src_addr = d;
    case (dir_q)
      2'd0:    src_addr = {dy, dx};
      2'd1:    src_addr = {~dx, dy};
      2'd2:    src_addr = {~dy, ~dx};
      default: src_addr = {dx, ~dy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
      dir_q    <= 2'd0;
      d        <= '0;
      iss_vld  <= 1'b0;
      iss_idx  <= '0;
`ifdef TANK_SPRITE_DBUF_EN
      active   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      iss_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_req) begin
            dir_q <= dir;
            busy  <= 1'b1;
            state <= S_WAIT_VBL;
          end
        end
        S_WAIT_VBL: begin
          if (vblnk_in) begin
            d     <= '0;
            state <= S_COPY;
          end
        end
        S_COPY: begin
          rom_addr <= src_addr;
          iss_vld  <= 1'b1;
          iss_idx  <= d;
          d        <= d + 1'b1;
          if (d == LAST_IDX) state <= S_FLUSH;
        end
        S_FLUSH: begin
`ifdef TANK_SPRITE_DBUF_EN
          state <= S_SWAP;
`else
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
`endif
        end
        S_SWAP: begin
`ifdef TANK_SPRITE_DBUF_EN
          if (vblnk_in) begin
            active <= ~active;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ROM answers one clk after rom_addr, so the destination index trails the issue by one more stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_vld <= iss_vld;
      wr_idx <= iss_idx;
    end
  end

  // A write already in flight when rst hits still lands; the image RAM has no reset.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
`ifdef TANK_SPRITE_DBUF_EN
      mem[{~active, wr_idx}] <= rom_data;
`else
      mem[wr_idx] <= rom_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_pixel <= '0;
    end else begin
`ifdef TANK_SPRITE_DBUF_EN
      rgb_pixel <= mem[{active, pixel_addr}];
`else
      rgb_pixel <= mem[pixel_addr];
`endif
    end
  end

endmodule

// File: tb/tb_tank_sprite_loader.sv
// Scoreboard bench for tank_sprite_loader; ROM contents equal their own address.
// Expected pixels come from an independent coordinate-rotation model.
module tb_tank_sprite_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic        vblnk_in;
  logic [1:0]  dir;
  logic        load_req;
  logic        busy;
  logic        done;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] sb[$];

`ifdef TANK_SPRITE_DBUF_EN
  localparam int BUSY_EXP = 4099;
`else
  localparam int BUSY_EXP = 4098;
`endif

  tank_sprite_loader dut (
    .clk(clk), .rst(rst), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .vblnk_in(vblnk_in), .dir(dir), .load_req(load_req), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom_addr;

  // Pixel at destination (y,x) for heading h, ROM word = source address.
  function automatic logic [11:0] exp_pix(input logic [1:0] h, input logic [11:0] a);
    int y, x, sy, sx;
    y = int'(a[11:6]);
    x = int'(a[5:0]);
    case (h)
      2'd0: begin sy = y;      sx = x;      end
      2'd1: begin sy = 63 - x; sx = y;      end
      2'd2: begin sy = 63 - y; sx = 63 - x; end
      default: begin sy = x;   sx = 63 - y; end
    endcase
    return 12'(sy * 64 + sx);
  endfunction

  task automatic run_load(input logic [1:0] dv, output int bcyc, output int ndone, output bit tout);
    dir = dv; load_req = 1'b1; vblnk_in = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    bcyc = 0; ndone = 0; tout = 1'b0;
    for (int n = 0; n < 10000 && busy; n++) begin
      bcyc++;
      if (done) ndone++;
      @(posedge clk); #1;
    end
    if (busy) tout = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; vblnk_in = 1'b0; dir = 2'd0; pixel_addr = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (rgb_pixel !== 12'h000) begin n_err++; $display("FAIL reset_rgb got=%h exp=000", rgb_pixel); end
    n_vec++; if (rom_addr !== 12'h000) begin n_err++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_dir(input logic [1:0] dv);
    int bcyc, ndone;
    bit tout;
    logic [11:0] al[$];
    logic [11:0] el[$];
    logic [11:0] a, e;
    run_load(dv, bcyc, ndone, tout);
    n_vec++;
    if (tout || bcyc !== BUSY_EXP) begin
      n_err++; $display("FAIL load%0d_busy_len got=%0d exp=%0d timeout=%0d", dv, bcyc, BUSY_EXP, tout);
    end
    n_vec++;
    if (ndone !== 1) begin n_err++; $display("FAIL load%0d_done_pulses got=%0d exp=1", dv, ndone); end
    case (dv)
      2'd0: begin al.push_back(12'h041); el.push_back(12'h041); end
      2'd1: begin al.push_back(12'h005); el.push_back(12'hE80); end
      default: begin
        al.push_back(12'h000); el.push_back(12'hFFF);
        al.push_back(12'h083); el.push_back(12'hF7C);
      end
    endcase
    al.push_back(12'hFFF); el.push_back(exp_pix(dv, 12'hFFF));
    al.push_back(12'h03F); el.push_back(exp_pix(dv, 12'h03F));
    for (int i = 0; i < 3; i++) begin
      a = 12'($urandom_range(0, 4095));
      al.push_back(a); el.push_back(exp_pix(dv, a));
    end
    while (al.size() > 0) begin
      a = al.pop_front();
      sb.push_back(el.pop_front());
      pixel_addr = a;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (rgb_pixel !== e) begin
        n_err++; $display("FAIL load%0d_read addr=%h got=%h exp=%h", dv, a, rgb_pixel, e);
      end
    end
  endtask

  task automatic test_wait_vbl();
    logic [11:0] r0, e, a;
    bit moved;
    int ndone, n;
    vblnk_in = 1'b0; dir = 2'd3; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wait_busy got=%b exp=1", busy); end
    r0 = rom_addr;
    moved = 1'b0; ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin load_req = 1'b1; dir = 2'd0; end
      if (i == 6) load_req = 1'b0;
      @(posedge clk); #1;
      if (rom_addr !== r0) moved = 1'b1;
      if (done) ndone++;
    end
    n_vec++; if (moved) begin n_err++; $display("FAIL wait_rom_static got=%h exp=%h", rom_addr, r0); end
    sb.push_back(12'hF7C);
    pixel_addr = 12'h083;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_vec++; if (rgb_pixel !== e) begin n_err++; $display("FAIL wait_no_write got=%h exp=%h", rgb_pixel, e); end
    vblnk_in = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (n == 50) load_req = 1'b1;
      if (n == 51) load_req = 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    vblnk_in = 1'b0;
    for (n = 0; n < 4200 && busy; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
`ifdef TANK_SPRITE_DBUF_EN
    n_vec++;
    if (busy !== 1'b1 || ndone !== 0) begin
      n_err++; $display("FAIL swap_waits_vbl busy=%b done_pulses=%0d exp busy=1 pulses=0", busy, ndone);
    end
    vblnk_in = 1'b1;
    for (n = 0; n < 10 && busy; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) moved = 1'b1;
    end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL wait_done_pulses got=%0d exp=1", ndone); end
    n_vec++; if (moved) begin n_err++; $display("FAIL wait_req_queued busy got=1 exp=0"); end
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 12'h005 : 12'($urandom_range(0, 4095));
      sb.push_back(exp_pix(2'd3, a));
      pixel_addr = a;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (rgb_pixel !== e) begin n_err++; $display("FAIL wait_dir3_read addr=%h got=%h exp=%h", a, rgb_pixel, e); end
    end
    vblnk_in = 1'b1;
  endtask

  task automatic test_reset_mid_copy();
    logic [11:0] al[$];
    logic [11:0] el[$];
    logic [11:0] a, e;
    int n, ndone;
    bit seen;
    dir = 2'd0; vblnk_in = 1'b1; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    for (n = 0; n < 3000 && rom_addr !== 12'd1000; n++) begin
      @(posedge clk); #1;
    end
    n_vec++; if (rom_addr !== 12'd1000) begin n_err++; $display("FAIL abort_reach_1000 got=%h exp=3e8", rom_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    ndone = 0;
    seen = done;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_vec++; if (seen || ndone !== 0) begin n_err++; $display("FAIL abort_done got=%0d exp=0", ndone + int'(seen)); end
`ifdef TANK_SPRITE_DBUF_EN
    al = '{12'd10, 12'd990, 12'd1010, 12'd4000};
    el = '{exp_pix(2'd3, 12'd10), exp_pix(2'd3, 12'd990), exp_pix(2'd3, 12'd1010), exp_pix(2'd3, 12'd4000)};
`else
    al = '{12'd10, 12'd990, 12'd1010, 12'd4000};
    el = '{12'd10, 12'd990, exp_pix(2'd3, 12'd1010), exp_pix(2'd3, 12'd4000)};
`endif
    while (al.size() > 0) begin
      a = al.pop_front();
      sb.push_back(el.pop_front());
      pixel_addr = a;
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (rgb_pixel !== e) begin n_err++; $display("FAIL abort_partial addr=%h got=%h exp=%h", a, rgb_pixel, e); end
    end
`ifdef TANK_SPRITE_DBUF_EN
    dir = 2'd2; vblnk_in = 1'b1; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(posedge clk); #1;
    vblnk_in = 1'b0;
    ndone = 0;
    for (n = 0; n < 4200; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_vec++;
    if (busy !== 1'b1 || ndone !== 0) begin
      n_err++; $display("FAIL reload_swap_held busy=%b pulses=%0d exp busy=1 pulses=0", busy, ndone);
    end
    sb.push_back(exp_pix(2'd3, 12'h083));
    pixel_addr = 12'h083;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_vec++; if (rgb_pixel !== e) begin n_err++; $display("FAIL reload_old_visible got=%h exp=%h", rgb_pixel, e); end
    vblnk_in = 1'b1;
    for (n = 0; n < 10 && busy; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL reload_done got=%0d exp=1", ndone); end
    sb.push_back(12'hF7C);
    pixel_addr = 12'h083;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_vec++; if (rgb_pixel !== e) begin n_err++; $display("FAIL reload_new_visible got=%h exp=%h", rgb_pixel, e); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_dir(2'd0);
    test_load_dir(2'd1);
    test_load_dir(2'd2);
    test_wait_vbl();
    test_reset_mid_copy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
